switch_debouncer: RTL and testbench



---
 rtl/switch_debouncer_if.sv | 43 ++++
 rtl/switch_debouncer.sv | 109 ++++++++++
 tb/tb_switch_debouncer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/switch_debouncer_if.sv
// Switch conditioning bus: raw pattern in, committed pattern and strobes out.
// Optional build macro SWDEB_TICK_EN adds the tick sample-enable signal.
interface switch_debouncer_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0] sw_raw;
`ifdef SWDEB_TICK_EN
  logic             tick;
`endif
  logic [WIDTH-1:0] sw_clean;
  logic             changed;
  logic             settling;

`ifdef SWDEB_TICK_EN
  modport master (
    output sw_raw,
    output tick,
    input  sw_clean,
    input  changed,
    input  settling
  );
  modport slave (
    input  sw_raw,
    input  tick,
    output sw_clean,
    output changed,
    output settling
  );
`else
  modport master (
    output sw_raw,
    input  sw_clean,
    input  changed,
    input  settling
  );
  modport slave (
    input  sw_raw,
    output sw_clean,
    output changed,
    output settling
  );
`endif
endinterface

// File: rtl/switch_debouncer.sv
// Synchronizes and debounces a multi-bit switch pattern, with a change strobe.
// Optional build macro SWDEB_TICK_EN: FSM advances only on tick cycles.
module switch_debouncer #(
  parameter int WIDTH           = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  switch_debouncer_if.slave   sw
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic {
    STABLE,
    SETTLING
  } state_t;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_sw;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] clean_q, clean_d;
  logic             changed_q, changed_d;
  logic             adv;

`ifdef SWDEB_TICK_EN
  assign adv = sw.tick;
`else
  assign adv = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
    end else begin
      sync_q[0] <= sw.sw_raw;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_sw = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= STABLE;
      cand_q    <= '0;
      cnt_q     <= '0;
      clean_q   <= '0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      clean_q   <= clean_d;
      changed_q <= changed_d;
    end
  end

  // Returning to the committed pattern beats restart, restart beats commit.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    clean_d   = clean_q;
    changed_d = 1'b0;
    if (adv) begin
      unique case (state_q)
        STABLE: begin
          if (sync_sw != clean_q) begin
            state_d = SETTLING;
            cand_d  = sync_sw;
            cnt_d   = CW'(1);
          end
        end
        SETTLING: begin
          if (sync_sw == clean_q) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (sync_sw != cand_q) begin
            cand_d = sync_sw;
            cnt_d  = CW'(1);
          end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            clean_d   = cand_q;
            changed_d = 1'b1;
            state_d   = STABLE;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign sw.sw_clean = clean_q;
  assign sw.changed  = changed_q;
  assign sw.settling = (state_q == SETTLING);

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: run-length reference model plus directed cases.
// Builds with or without SWDEB_TICK_EN.
module tb_switch_debouncer;

  localparam int S    = 2;
  localparam int D    = 4;
  localparam int HOLD = 24;

  logic clk = 1'b0;
  logic reset_n;

  switch_debouncer_if #(.WIDTH(2)) bus ();

  switch_debouncer #(
    .WIDTH(2),
    .SYNC_STAGES(S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sw(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  logic tick_s;
`ifdef SWDEB_TICK_EN
  int tdiv = 0;
  initial bus.tick = 1'b0;
  always @(negedge clk) begin
    tdiv = (tdiv + 1) % 4;
    bus.tick = (tdiv == 0);
  end
  assign tick_s = bus.tick;
`else
  assign tick_s = 1'b1;
`endif

  // Model: a pattern commits once it has been the synchronized sample
  // D times in a row while differing from the committed pattern.
  logic [1:0] m_line[$];
  logic [1:0] m_seen, m_last, m_clean;
  int         m_run;
  logic       m_chg, m_settle;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_line = {};
      for (int i = 0; i < S; i++) m_line.push_back(2'b00);
      m_last   = 2'b00;
      m_clean  = 2'b00;
      m_run    = 0;
      m_chg    = 1'b0;
      m_settle = 1'b0;
    end else begin
      m_seen = m_line.pop_front();
      m_line.push_back(bus.sw_raw);
      m_chg = 1'b0;
      if (tick_s) begin
        if (m_seen == m_last) m_run++;
        else m_run = 1;
        m_last = m_seen;
        if (m_seen != m_clean && m_run >= D) begin
          m_clean = m_seen;
          m_chg   = 1'b1;
        end
        m_settle = (m_last != m_clean);
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if (bus.sw_clean !== m_clean || bus.changed !== m_chg ||
        bus.settling !== m_settle) begin
      errors++;
      $display("FAIL model t=%0t clean=%b/%b changed=%b/%b settling=%b/%b",
               $time, bus.sw_clean, m_clean, bus.changed, m_chg,
               bus.settling, m_settle);
    end
    if (bus.changed === 1'b1) pulses++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
`ifndef SWDEB_TICK_EN
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
`endif
  endtask

  int p0;

  initial begin
    reset_n    = 1'b1;
    bus.sw_raw = 2'b11;
    #1 reset_n = 1'b0;
    #3;
    lit("rst_clean", 32'(bus.sw_clean), 0);
    lit("rst_changed", 32'(bus.changed), 0);
    lit("rst_settling", 32'(bus.settling), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    p0 = pulses;
    step(5);
    lit("t1_e5_clean", 32'(bus.sw_clean), 0);
    step(1);
    lit("t1_e6_clean", 32'(bus.sw_clean), 3);
    lit("t1_e6_changed", 32'(bus.changed), 1);
    step(1);
    lit("t1_e7_changed", 32'(bus.changed), 0);
    step(HOLD);
    lit("t1_pulses", 32'(pulses - p0), 1);

    bus.sw_raw = 2'b00;
    reset_n    = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(3);
    lit("t2_start_clean", 32'(bus.sw_clean), 0);
    p0 = pulses;
    bus.sw_raw = 2'b01;
    step(2);
    lit("t2_e2_settling", 32'(bus.settling), 0);
    step(1);
    lit("t2_e3_settling", 32'(bus.settling), 1);
    step(2);
    lit("t2_e5_clean", 32'(bus.sw_clean), 0);
    step(1);
    lit("t2_e6_clean", 32'(bus.sw_clean), 1);
    lit("t2_e6_changed", 32'(bus.changed), 1);
    step(1);
    lit("t2_e7_changed", 32'(bus.changed), 0);
    step(HOLD);
    lit("t2_pulses", 32'(pulses - p0), 1);

    p0 = pulses;
    bus.sw_raw = 2'b00;
    step(2);
    bus.sw_raw = 2'b01;
    step(HOLD);
    lit("t3_clean", 32'(bus.sw_clean), 1);
    lit("t3_settling", 32'(bus.settling), 0);
    lit("t3_pulses", 32'(pulses - p0), 0);

    bus.sw_raw = 2'b00;
    step(HOLD);
    lit("t4_start_clean", 32'(bus.sw_clean), 0);
    p0 = pulses;
    for (int i = 0; i < 4; i++) begin
      bus.sw_raw = (i % 2 == 0) ? 2'b10 : 2'b00;
      step(1);
    end
    bus.sw_raw = 2'b10;
    step(5);
    lit("t4_e5_clean", 32'(bus.sw_clean), 0);
    step(1);
    lit("t4_e6_clean", 32'(bus.sw_clean), 2);
    lit("t4_e6_changed", 32'(bus.changed), 1);
    step(HOLD);
    lit("t4_pulses", 32'(pulses - p0), 1);

    bus.sw_raw = 2'b00;
    step(HOLD);
    p0 = pulses;
    bus.sw_raw = 2'b01;
    step(2);
    bus.sw_raw = 2'b11;
    step(5);
    lit("t5_e5_clean", 32'(bus.sw_clean), 0);
    step(1);
    lit("t5_e6_clean", 32'(bus.sw_clean), 3);
    step(HOLD);
    lit("t5_pulses", 32'(pulses - p0), 1);

    bus.sw_raw = 2'b00;
    step(4);
    lit("t6_settling", 32'(bus.settling), 1);
    #2 reset_n = 1'b0;
    #1;
    lit("t6_rst_clean", 32'(bus.sw_clean), 0);
    lit("t6_rst_changed", 32'(bus.changed), 0);
    lit("t6_rst_settling", 32'(bus.settling), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    p0 = pulses;
    step(HOLD);
    lit("t6_pulses", 32'(pulses - p0), 0);
    lit("t6_clean", 32'(bus.sw_clean), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
